// File: rtl/fre_track_avg.sv
// Frequency-judge controller: triggers the judge, averages 2^AVG_LOG2 period results and flags lock.
// Optional output smoothing is enabled by defining FRE_TRACK_AVG_IIR_EN.
`timescale 1ns/1ps

module fre_track_avg #(
  parameter int          IN_WIDTH    = 18,
  parameter int          AVG_LOG2    = 2,
  parameter logic [31:0] TIMEOUT_NUM = 32'd200000,
  parameter logic [15:0] GAP_NUM     = 16'd100,
  parameter int          TOL_SHIFT   = 3,
  parameter int          IIR_SHIFT   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                judge_start,
  input  logic [IN_WIDTH-1:0] fre_in,
  input  logic                fre_vld,
  output logic [IN_WIDTH-1:0] fre_out,
  output logic                fre_dready,
  output logic                locked,
  output logic                timeout,
  output logic [7:0]          err_cnt
);

  localparam int SUM_W = IN_WIDTH + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_IDX     = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [31:0]      TIMEOUT_LAST = TIMEOUT_NUM - 32'd1;
  localparam logic [15:0]      GAP_LAST     = GAP_NUM - 16'd1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_TRIG = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_CALC = 3'd4;
  localparam logic [2:0] ST_OUT  = 3'd5;

  if (TIMEOUT_NUM == 32'd0 || GAP_NUM == 16'd0 || AVG_LOG2 < 0 || TOL_SHIFT < 0 ||
      IIR_SHIFT < 0 || IIR_SHIFT > IN_WIDTH) begin : g_param_check
    $error("fre_track_avg: illegal parameter combination");
  end

  logic [2:0]          state_q, state_d;
  logic [31:0]         timer_q, timer_d;
  logic [15:0]         gap_q, gap_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IN_WIDTH-1:0] min_q, min_d;
  logic [IN_WIDTH-1:0] max_q, max_d;
  logic [IN_WIDTH-1:0] fre_out_q, fre_out_d;
  logic                locked_q, locked_d;
  logic                dready_q, dready_d;
  logic [7:0]          err_q, err_d;

  logic [IN_WIDTH-1:0] avg, spread, tol, result;
  logic [7:0]          err_inc;

  assign avg     = sum_q[SUM_W-1:AVG_LOG2];
  assign spread  = max_q - min_q;
  assign tol     = avg >> TOL_SHIFT;
  assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

`ifdef FRE_TRACK_AVG_IIR_EN
  logic                       have_prev_q, have_prev_d;
  logic signed [IN_WIDTH:0]   iir_diff, iir_step;
  logic        [IN_WIDTH:0]   iir_sum;

  // The difference is signed so a falling average pulls the output down.
  always_comb begin
    iir_diff = $signed({1'b0, avg}) - $signed({1'b0, fre_out_q});
    iir_step = iir_diff >>> IIR_SHIFT;
    iir_sum  = {1'b0, fre_out_q} + $unsigned(iir_step);
    result   = have_prev_q ? iir_sum[IN_WIDTH-1:0] : avg;
  end

  always_comb begin
    have_prev_d = have_prev_q;
    if (state_q == ST_CALC) have_prev_d = 1'b1;
    else if (timeout)       have_prev_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) have_prev_q <= 1'b0;
    else        have_prev_q <= have_prev_d;
  end
`else
  assign result = avg;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    min_d       = min_q;
    max_d       = max_q;
    fre_out_d   = fre_out_q;
    locked_d    = locked_q;
    dready_d    = 1'b0;
    err_d       = err_q;
    judge_start = 1'b0;
    timeout     = 1'b0;

    case (state_q)
      ST_IDLE: if (en) state_d = ST_TRIG;
      ST_TRIG: begin
        judge_start = 1'b1;
        timer_d     = '0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 32'd1;
        gap_d   = '0;
        if (fre_vld && fre_in != '0) begin
          sum_d = sum_q + SUM_W'(fre_in);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) begin
            min_d = fre_in;
            max_d = fre_in;
          end else begin
            if (fre_in < min_q) min_d = fre_in;
            if (fre_in > max_q) max_d = fre_in;
          end
          state_d = (cnt_q == LAST_IDX) ? ST_CALC : ST_GAP;
        end else if (fre_vld) begin
          err_d   = err_inc;
          state_d = ST_GAP;
        end else if (timer_q == TIMEOUT_LAST) begin
          timeout  = 1'b1;
          sum_d    = '0;
          cnt_d    = '0;
          min_d    = '0;
          max_d    = '0;
          locked_d = 1'b0;
          err_d    = err_inc;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = en ? ST_TRIG : ST_IDLE;
        else                   gap_d   = gap_q + 16'd1;
      end
      // Outputs load on leaving CALC so they are visible while in OUT.
      ST_CALC: begin
        fre_out_d = result;
        locked_d  = (spread <= tol);
        dready_d  = 1'b1;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        sum_d   = '0;
        cnt_d   = '0;
        min_d   = '0;
        max_d   = '0;
        gap_d   = '0;
        state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      gap_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      fre_out_q <= '0;
      locked_q  <= 1'b0;
      dready_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
      fre_out_q <= fre_out_d;
      locked_q  <= locked_d;
      dready_q  <= dready_d;
      err_q     <= err_d;
    end
  end

  assign fre_out    = fre_out_q;
  assign fre_dready = dready_q;
  assign locked     = locked_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_fre_track_avg.sv
// Directed bench for fre_track_avg: judge stub driven from tables plus hand-written corner sequences.
`timescale 1ns/1ps

module tb_fre_track_avg;
  localparam int W   = 18;
  localparam int TO  = 50;
  localparam int GAP = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         fre_vld = 1'b0;
  logic [W-1:0] fre_in = '0;
  logic         judge_start, fre_dready, locked, timeout;
  logic [W-1:0] fre_out;
  logic [7:0]   err_cnt;

  fre_track_avg #(
    .IN_WIDTH(W), .AVG_LOG2(2), .TIMEOUT_NUM(32'(TO)), .GAP_NUM(16'(GAP)),
    .TOL_SHIFT(3), .IIR_SHIFT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .judge_start(judge_start),
    .fre_in(fre_in), .fre_vld(fre_vld), .fre_out(fre_out),
    .fre_dready(fre_dready), .locked(locked), .timeout(timeout), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;
  int next_start = -1;

  typedef struct packed {
    logic [3:0][W-1:0] s;
    logic [W-1:0]      exp_out;
    logic              exp_lock;
  } set_t;

  set_t vecs[5];

  function automatic set_t mk(input int a, input int b, input int c, input int d,
                              input int eo, input bit el);
    set_t r;
    r.s[0] = W'(a); r.s[1] = W'(b); r.s[2] = W'(c); r.s[3] = W'(d);
    r.exp_out = W'(eo); r.exp_lock = el;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int b = 0; b < 2000; b++) begin
      @(negedge clk);
      if (judge_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One judge transaction: answer 'd' cycles after judge_start, then check the result timing.
  task automatic do_sample(input logic [W-1:0] v, input int d, input bit fin,
                           input int exp_out, input bit exp_lock, input string tag);
    bit ok;
    int v_cyc;
    wait_start(ok);
    check({tag, "_start_seen"}, int'(ok), 1);
    if (!ok) return;
    if (next_start >= 0) check({tag, "_start_time"}, cyc, next_start);
    @(negedge clk);
    check({tag, "_start_width"}, int'(judge_start), 0);
    repeat (d - 1) @(negedge clk);
    fre_in  = v;
    fre_vld = 1'b1;
    v_cyc   = cyc;
    @(negedge clk);
    fre_vld = 1'b0;
    fre_in  = '0;
    check({tag, "_dready_early"}, int'(fre_dready), 0);
    @(negedge clk);
    check({tag, "_dready"}, int'(fre_dready), int'(fin));
    if (fin) begin
      check({tag, "_fre_out"}, int'(fre_out), exp_out);
      check({tag, "_locked"}, int'(locked), int'(exp_lock));
      next_start = v_cyc + GAP + 3;
    end else begin
      next_start = v_cyc + GAP + 1;
    end
  endtask

  task automatic run_set(input set_t sv, input int idx);
    for (int k = 0; k < 4; k++)
      do_sample(sv.s[k], 1 + ((idx * 3 + k) % 5), k == 3, int'(sv.exp_out), sv.exp_lock,
                $sformatf("set%0d_s%0d", idx, k));
  endtask

  task automatic do_timeout(input int exp_err, input string tag);
    bit ok;
    int s_cyc;
    int t_cyc;
    wait_start(ok);
    check({tag, "_start_seen"}, int'(ok), 1);
    if (!ok) return;
    if (next_start >= 0) check({tag, "_start_time"}, cyc, next_start);
    s_cyc = cyc;
    t_cyc = -1;
    for (int t = 0; t < TO + 5; t++) begin
      @(negedge clk);
      if (timeout) begin
        t_cyc = cyc;
        break;
      end
    end
    check({tag, "_timeout_time"}, t_cyc, s_cyc + TO);
    @(negedge clk);
    check({tag, "_timeout_width"}, int'(timeout), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), exp_err);
    check({tag, "_locked"}, int'(locked), 0);
    next_start = t_cyc + GAP + 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    vecs[0] = mk(1000, 1002,  998, 1000, 1000, 1'b1);
    vecs[1] = mk(1000, 1200,  900, 1100, 1050, 1'b0);
    vecs[2] = mk(2000, 2003, 1999, 2001, 2000, 1'b1);
    vecs[3] = mk( 750,  750,  850,  850,  800, 1'b1);
    vecs[4] = mk( 750,  851,  750,  851,  800, 1'b0);

    repeat (2) @(negedge clk);
    check("rst_fre_out", int'(fre_out), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_dready", int'(fre_dready), 0);
    check("rst_start", int'(judge_start), 0);
    check("rst_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    en    = 1'b1;

`ifdef FRE_TRACK_AVG_IIR_EN
    run_set(mk(1000, 1000, 1000, 1000, 1000, 1'b1), 0);
    run_set(mk(1400, 1400, 1400, 1400, 1100, 1'b1), 1);
    run_set(mk(1400, 1400, 1400, 1400, 1175, 1'b1), 2);
`else
    for (int i = 0; i < 5; i++) run_set(vecs[i], i);

    // A zero period is rejected and does not count toward the set.
    do_sample(W'(500), 2, 1'b0, 0, 1'b0, "rej_a");
    do_sample(W'(0),   3, 1'b0, 0, 1'b0, "rej_zero");
    check("rej_err_cnt", int'(err_cnt), 1);
    do_sample(W'(510), 1, 1'b0, 0, 1'b0, "rej_b");
    do_sample(W'(490), 4, 1'b0, 0, 1'b0, "rej_c");
    do_sample(W'(500), 2, 1'b1, 500, 1'b1, "rej_d");

    // Silent judge: first timeout, then saturation of err_cnt.
    do_timeout(2, "to_first");
    for (int i = 1; i <= 300; i++)
      do_timeout((2 + i > 255) ? 255 : 2 + i, $sformatf("to%0d", i));
    check("to_err_saturated", int'(err_cnt), 255);

    // en dropped during WAIT: finish the wait, then idle with the partial set kept.
    begin
      bit ok;
      wait_start(ok);
      check("endrop_start_seen", int'(ok), 1);
      en = 1'b0;
      repeat (3) @(negedge clk);
      fre_in  = W'(700);
      fre_vld = 1'b1;
      @(negedge clk);
      fre_vld = 1'b0;
      fre_in  = '0;
      starts = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (judge_start) starts++;
      end
      check("endrop_no_start", starts, 0);
      en = 1'b1;
      next_start = cyc + 1;
      do_sample(W'(700), 1, 1'b0, 0, 1'b0, "resume_a");
      do_sample(W'(700), 2, 1'b0, 0, 1'b0, "resume_b");
      do_sample(W'(700), 3, 1'b1, 700, 1'b1, "resume_c");
    end

    // Reset asserted while in GAP.
    do_sample(W'(710), 2, 1'b0, 0, 1'b0, "prerst");
    rst_n = 1'b0;
    #1;
    check("midrst_fre_out", int'(fre_out), 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_err_cnt", int'(err_cnt), 0);
    check("midrst_dready", int'(fre_dready), 0);
    check("midrst_timeout", int'(timeout), 0);
    starts = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (judge_start) starts++;
    end
    check("midrst_no_start", starts, 0);
    rst_n = 1'b1;
    next_start = cyc + 1;
    begin
      bit ok;
      wait_start(ok);
      check("postrst_start_seen", int'(ok), 1);
      check("postrst_start_time", cyc, next_start);
    end
`endif

    en = 1'b0;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fre_track_avg.md
Name: fre_track_avg

Overview:
- Sits directly downstream of the frequency-judge stage and acts as its controller.
- Issues the judge's one-cycle start pulse, collects 2^AVG_LOG2 valid period results (fre/dready) and averages them.
- Checks the spread of those results for a lock indication and re-triggers continuously while enabled.
- Feeds the averaged period to the demodulator's carrier/NCO setup logic.

Parameters:
- IN_WIDTH, 18: width of the period count from the judge stage.
- AVG_LOG2, 2: log2 of valid samples averaged per result (4).
- TIMEOUT_NUM, 32'd200000: clk cycles to wait for judge dready before declaring timeout.
- GAP_NUM, 16'd100: idle clk cycles between a judge dready (or timeout) and the next start.
- TOL_SHIFT, 3: lock tolerance = avg >> TOL_SHIFT (12.5 %).
- IIR_SHIFT, 2: smoothing shift, used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  level enable; low returns the block to idle after the current wait
- judge_start  out  1  one-cycle start pulse to the judge stage
- fre_in  in  IN_WIDTH  period count from the judge stage
- fre_vld  in  1  judge dready, one-cycle pulse
- fre_out  out  IN_WIDTH  averaged period count
- fre_dready  out  1  one-cycle pulse when fre_out updates
- locked  out  1  spread of the last set is within tolerance
- timeout  out  1  one-cycle pulse on judge timeout
- err_cnt  out  8  saturating count of rejected/timeout events since reset

Behaviour:
- Reset values: all outputs 0. Accumulator, sample count, min/max, timers and previous result also clear to 0.
- State machine states: ST_IDLE, ST_TRIG, ST_WAIT, ST_GAP, ST_CALC, ST_OUT.
- ST_IDLE: when en=1, go to ST_TRIG.
- ST_TRIG: judge_start=1 for exactly this cycle, clear the timeout counter, go to ST_WAIT.
- ST_WAIT: count cycles.
  - fre_vld=1 and fre_in!=0: accumulate fre_in into a sum of width IN_WIDTH+AVG_LOG2 (no overflow possible) and update min/max. The first sample of a set loads both min and max. Increment the sample count, then go to ST_CALC if the count reaches 2^AVG_LOG2, else to ST_GAP.
  - fre_vld=1 and fre_in==0: reject the sample, increment err_cnt, go to ST_GAP.
  - Counter reaches TIMEOUT_NUM-1 without fre_vld: pulse timeout, clear the set (sum, count, min/max), clear locked, increment err_cnt, go to ST_GAP.
  - fre_vld and timeout in the same cycle: fre_vld wins, no timeout pulse.
- ST_GAP: wait GAP_NUM cycles. Then go to ST_TRIG if en=1, else to ST_IDLE. fre_vld arriving here is ignored.
- ST_CALC (one cycle):
  - avg = sum >> AVG_LOG2, truncating.
  - spread = max - min.
  - locked_next = (spread <= (avg >> TOL_SHIFT)).
- ST_OUT (one cycle): register fre_out and locked, pulse fre_dready, clear the set, go to ST_GAP.
- Latency: fre_dready rises 2 cycles after the fre_vld that completes a set.
- Timing between starts: GAP_NUM+1 cycles from a non-final fre_vld to the next judge_start. A final sample adds 2 cycles.
- en deasserted:
  - In ST_WAIT: keep waiting for fre_vld or timeout, then ST_GAP, then ST_IDLE.
  - In ST_IDLE: the partial set is kept. en re-asserting resumes it.
- Reset asserted mid-operation: immediate return to ST_IDLE with all reset values. No judge_start is emitted during reset.
- err_cnt saturates at 255.

Optional Feature:
- Macro: FRE_TRACK_AVG_IIR_EN.
- Defined: after the first result, fre_out = prev + ((avg - prev) >>> IIR_SHIFT), using signed IN_WIDTH+1 difference arithmetic. The first result after reset or after any timeout loads avg directly. locked is still computed from the raw set spread.
- Undefined: fre_out = avg directly. The IIR_SHIFT parameter is unused.

Test Plan:
- Judge stub returns 1000, 1002, 998, 1000 (AVG_LOG2=2):
  - Required: one judge_start per sample, GAP_NUM+1 cycles apart.
  - fre_dready 2 cycles after the 4th fre_vld, fre_out=1000, locked=1.
- Judge stub returns 1000, 1200, 900, 1100:
  - avg=1050, spread=300 > 131.
  - Required: fre_out=1050, locked=0.
- Judge stub never responds, TIMEOUT_NUM=50:
  - timeout pulses 50 cycles after judge_start.
  - Required: err_cnt=1, locked=0, next judge_start GAP_NUM+1 cycles later.
  - Repeat 300 times: err_cnt holds at 255.
- fre_in=0 returned once among valid samples:
  - Required: sample rejected, err_cnt+1, and the set completes only after 4 nonzero samples.
- Reset mid-operation:
  - Drop en during ST_WAIT: required to finish the wait and then idle with no further judge_start.
  - Assert rst_n=0 during ST_GAP: all outputs 0 immediately, and a new start follows only after release with en=1.
- With FRE_TRACK_AVG_IIR_EN, IIR_SHIFT=2:
  - Set 1 averaging 1000: required fre_out=1000.
  - Set 2 averaging 1400: required fre_out=1100.
